alu_serial_seq: RTL and testbench

Bit-serial ALU sequencer that sits directly upstream of the 1-bit ALU slice datapath. It accepts full-width operands and a 4-bit ALU control code, then drives them one bit per clock, LSB first, through a single slice-equivalent (ainvert/binvert/carry/operation logic). It accumulates the result word and produces overflow and zero flags. It trades a W-cycle latency for one slice of logic and is used in the area-reduced class-report CPU variant.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_serial_bit.sv | 32 +++
 rtl/alu_serial_seq.sv | 135 +++++++++++++
 tb/tb_alu_serial_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, FSM states and slice-control decode for the ALU family.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_e;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_SUM, OP_LESS} op_e;

  typedef struct packed {
    logic legal;
    logic ainv;
    logic binv;
    op_e  op;
  } ctl_t;

  function automatic ctl_t decode_ctl(input logic [3:0] ctl);
    ctl_t c;
    c = '{legal: 1'b0, ainv: 1'b0, binv: 1'b0, op: OP_AND};
    case (ctl)
      ALU_AND: c = '{legal: 1'b1, ainv: 1'b0, binv: 1'b0, op: OP_AND};
      ALU_OR:  c = '{legal: 1'b1, ainv: 1'b0, binv: 1'b0, op: OP_OR};
      ALU_ADD: c = '{legal: 1'b1, ainv: 1'b0, binv: 1'b0, op: OP_SUM};
      ALU_SUB: c = '{legal: 1'b1, ainv: 1'b0, binv: 1'b1, op: OP_SUM};
      ALU_SLT: c = '{legal: 1'b1, ainv: 1'b0, binv: 1'b1, op: OP_LESS};
      ALU_NOR: c = '{legal: 1'b1, ainv: 1'b1, binv: 1'b1, op: OP_AND};
      default: c = '{legal: 1'b0, ainv: 1'b0, binv: 1'b0, op: OP_AND};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// Combinational 1-bit ALU slice: operand inversion, full adder, and/or/sum select.
module alu_serial_bit
  import alu_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic ainv,
  input  logic binv,
  input  logic carry,
  input  op_e  op,
  output logic res_bit,
  output logic sum,
  output logic cout
);

  logic ax, bx;

  always_comb begin
    ax      = ai ^ ainv;
    bx      = bi ^ binv;
    sum     = ax ^ bx ^ carry;
    cout    = (ax & bx) | (ax & carry) | (bx & carry);
    res_bit = 1'b0;
    case (op)
      OP_AND:  res_bit = ax & bx;
      OP_OR:   res_bit = ax | bx;
      OP_SUM:  res_bit = sum;
      default: res_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: latches operands, runs one slice LSB-first for W cycles.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int W  = 32,
  localparam int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   alu_ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         err
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    ctl_q, ctl_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

  ctl_t in_ctl, cur_ctl;
  logic res_bit, sum_bit, cout_bit, last, v_msb;

  assign in_ctl  = decode_ctl(alu_ctl);
  assign cur_ctl = decode_ctl(ctl_q);
  assign last    = (cnt_q == CW'(W - 1));
  assign v_msb   = carry_q ^ cout_bit;

  alu_serial_bit u_bit (
    .ai      (a_q[cnt_q]),
    .bi      (b_q[cnt_q]),
    .ainv    (cur_ctl.ainv),
    .binv    (cur_ctl.binv),
    .carry   (carry_q),
    .op      (cur_ctl.op),
    .res_bit (res_bit),
    .sum     (sum_bit),
    .cout    (cout_bit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = '0;
          if (in_ctl.legal) begin
            a_d     = a;
            b_d     = b;
            ctl_d   = alu_ctl;
            carry_d = in_ctl.binv;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ST_SHIFT;
          end else begin
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            zero_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_SHIFT: begin
        result_d[cnt_q] = res_bit;
        carry_d         = cout_bit;
        if (last) begin
          // MSB carries are consumed on this edge so flags are already valid during FINISH
          ovf_d = ((ctl_q == ALU_ADD) || (ctl_q == ALU_SUB)) ? v_msb : 1'b0;
          if (cur_ctl.op == OP_LESS) begin
            result_d    = '0;
            result_d[0] = sum_bit ^ v_msb;
          end
          zero_d  = (result_d == '0);
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FINISH);
  assign result   = result_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed plan items plus random ops vs an arithmetic model.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alu_ctl;
  logic [W-1:0] a, b;
  logic         busy, done, overflow, zero, err;
  logic [W-1:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_serial_seq #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctl  (alu_ctl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .zero     (zero),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on whole words.
  task automatic model(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] r, output logic ov, output logic e);
    r = '0; ov = 1'b0; e = 1'b0;
    case (ctl)
      ALU_AND: r = av & bv;
      ALU_OR:  r = av | bv;
      ALU_NOR: r = ~(av | bv);
      ALU_ADD: begin
        r  = av + bv;
        ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
      end
      ALU_SUB: begin
        r  = av - bv;
        ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
      end
      ALU_SLT: r = ($signed(av) < $signed(bv)) ? W'(1) : W'(0);
      default: e = 1'b1;
    endcase
  endtask

  // Start one op, optionally poke start again at cycle `poke`, wait for done, check everything.
  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input int unsigned poke);
    logic [W-1:0] er;
    logic eo, ee;
    int unsigned n;
    model(ctl, av, bv, er, eo, ee);
    @(negedge clk);
    start = 1'b1; alu_ctl = ctl; a = av; b = bv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = (poke != 0) && (n == poke);
      a = $urandom; b = $urandom;
      if (start) alu_ctl = ALU_SUB;
      if (n == 1) chk({tag, ".busy1"}, 64'(busy), 64'(1));
    end while (!done && n < 100);
    chk({tag, ".latency"}, 64'(n), ee ? 64'(1) : 64'(W + 1));
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
    chk({tag, ".zero"}, 64'(zero), 64'(er == '0));
    chk({tag, ".err"}, 64'(err), 64'(ee));
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".done_drop"}, 64'(done), 64'(0));
    chk({tag, ".busy_drop"}, 64'(busy), 64'(0));
    chk({tag, ".hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [3:0] legal_ctl [6];
    int unsigned dones;
    legal_ctl = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
    rst = 1'b1; start = 1'b0; alu_ctl = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.result", 64'(result), 64'(0));
    chk("reset.flags", {61'(0), overflow, zero, err}, 64'(0));
    rst = 1'b0;

    do_op("add7_5", ALU_ADD, 32'd7, 32'd5, 0);
    do_op("sub_ovf", ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("sub_eq", ALU_SUB, 32'd5, 32'd5, 0);
    do_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("slt_corr", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    do_op("nor0", ALU_NOR, 32'd0, 32'd0, 0);
    do_op("and", ALU_AND, 32'hF0, 32'h0F, 0);
    do_op("or", ALU_OR, 32'hF0, 32'h0F, 0);
    do_op("illegal", 4'b0101, 32'd9, 32'd3, 0);
    do_op("add_after_err", ALU_ADD, 32'd1, 32'd2, 0);
    do_op("add_poke", ALU_ADD, 32'h1234_5678, 32'h0F0F_0F0F, 5);
    do_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0);

    // Reset in the middle of a SUB aborts it with no done.
    @(negedge clk);
    start = 1'b1; alu_ctl = ALU_SUB; a = 32'd100; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.busy", 64'(busy), 64'(0));
    chk("rst_mid.done", 64'(done), 64'(0));
    chk("rst_mid.result", 64'(result), 64'(0));
    chk("rst_mid.flags", {61'(0), overflow, zero, err}, 64'(0));
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid.no_done", 64'(dones), 64'(0));
    do_op("after_rst", ALU_SUB, 32'd100, 32'd1, 0);

    for (int unsigned i = 0; i < 40; i++) begin
      logic [3:0] c;
      logic [W-1:0] av, bv;
      c  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ctl[$urandom_range(0, 5)];
      av = $urandom; bv = $urandom;
      case ($urandom_range(0, 5))
        0: bv = av;
        1: av = 32'h8000_0000;
        2: bv = 32'h7FFF_FFFF;
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), c, av, bv, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
